// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 interrupt controller: register indices and FSM states.
package cp0_pkg;

    localparam logic [1:0] CP0_IE  = 2'd0;
    localparam logic [1:0] CP0_INM = 2'd1;
    localparam logic [1:0] CP0_EPC = 2'd2;

    typedef enum logic [3:0] {
        StInitIe,
        StInitMsk,
        StInitEpc,
        StIdle,
        StChkIe,
        StChkMsk,
        StSaveEpc,
        StClrIe,
        StJump,
        StRetIe,
        StRetJump
    } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; index 0 is the highest priority request.
module irq_prio_enc #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [2:0]   o_idx
);

    // Scan from the top down so the lowest set index is the last one assigned.
    always_comb begin
        o_valid = |i_req;
        o_idx   = 3'd0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/cp0_int_ctrl.sv
// Interrupt sequencer and CP0 write-port arbiter: initialises CP0, takes interrupts at
// instruction boundaries (save EPC, clear IE, jump to vector) and handles ERET.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned NIRQ       = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic            in_CLK,
    input  logic            in_RST,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            instr_done,
    input  logic [31:0]     pc_next,
    input  logic            eret,
    input  logic            cpu_we,
    input  logic [1:0]      cpu_rW,
    input  logic [31:0]     cpu_W,
    input  logic [31:0]     cp0_A,
    input  logic [31:0]     cp0_EPC,
    output logic            cp0_WE,
    output logic [1:0]      cp0_rW,
    output logic [31:0]     cp0_W,
    output logic [2:0]      cp0_rA,
    output logic            cpu_stall,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic [NIRQ-1:0] irq_ack
);

    state_e          r_state;
    state_e          w_next_state;
    logic [NIRQ-1:0] r_pend;
    logic [NIRQ-1:0] w_pend_next;
    logic [NIRQ-1:0] r_irq_q;
    logic [31:0]     r_ret_pc;
    logic [2:0]      r_sel;

    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_elig;
    logic            w_enc_valid;
    logic [2:0]      w_enc_idx;
    logic            w_take;
    logic            w_sel_load;
    logic            w_clr;
    logic [31:0]     w_vec_pc;
    logic            w_unused;

    assign w_rise   = irq_in & ~r_irq_q;
    // INM bit set means that IRQ line is masked.
    assign w_elig   = r_pend & ~cp0_A[NIRQ-1:0];
    assign w_vec_pc = VEC_BASE + 32'(r_sel) * VEC_STRIDE;
    assign w_unused = ^cp0_A[31:NIRQ];

    irq_prio_enc #(
        .N (NIRQ)
    ) u_prio_enc (
        .i_req   (w_elig),
        .o_valid (w_enc_valid),
        .o_idx   (w_enc_idx)
    );

    // Pending set: clear the serviced line, then OR in new edges so a set wins.
    always_comb begin
        w_pend_next = r_pend;
        for (int i = 0; i < int'(NIRQ); i++) begin
            if (w_clr && (r_sel == 3'(i))) begin
                w_pend_next[i] = 1'b0;
            end
        end
        w_pend_next = w_pend_next | w_rise;
    end

    // Next-state and output decode; outputs are forced idle while reset is held.
    always_comb begin
        w_next_state = r_state;
        cp0_WE       = 1'b0;
        cp0_rW       = 2'd0;
        cp0_W        = 32'd0;
        cp0_rA       = 3'd0;
        cpu_stall    = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        irq_ack      = '0;
        w_take       = 1'b0;
        w_sel_load   = 1'b0;
        w_clr        = 1'b0;
        unique case (r_state)
            StInitIe: begin
                cp0_WE       = 1'b1;
                cp0_rW       = CP0_IE;
                w_next_state = StInitMsk;
            end
            StInitMsk: begin
                cp0_WE       = 1'b1;
                cp0_rW       = CP0_INM;
                w_next_state = StInitEpc;
            end
            StInitEpc: begin
                cp0_WE       = 1'b1;
                cp0_rW       = CP0_EPC;
                w_next_state = StIdle;
            end
            StIdle: begin
                cpu_stall = 1'b0;
                cp0_WE    = cpu_we;
                cp0_rW    = cpu_rW;
                cp0_W     = cpu_W;
                if (eret) begin
                    w_next_state = StRetIe;
                end else if (instr_done && (r_pend != '0)) begin
                    w_take       = 1'b1;
                    w_next_state = StChkIe;
                end
            end
            StChkIe: begin
                cp0_rA       = {1'b0, CP0_IE};
                w_next_state = cp0_A[0] ? StChkMsk : StIdle;
            end
            StChkMsk: begin
                cp0_rA = {1'b0, CP0_INM};
                if (w_enc_valid) begin
                    w_sel_load   = 1'b1;
                    w_next_state = StSaveEpc;
                end else begin
                    w_next_state = StIdle;
                end
            end
            StSaveEpc: begin
                cp0_WE       = 1'b1;
                cp0_rW       = CP0_EPC;
                cp0_W        = r_ret_pc;
                w_next_state = StClrIe;
            end
            StClrIe: begin
                cp0_WE = 1'b1;
                cp0_rW = CP0_IE;
                w_clr  = 1'b1;
                for (int i = 0; i < int'(NIRQ); i++) begin
                    if (r_sel == 3'(i)) begin
                        irq_ack[i] = 1'b1;
                    end
                end
                w_next_state = StJump;
            end
            StJump: begin
                redirect     = 1'b1;
                redirect_pc  = w_vec_pc;
                w_next_state = StIdle;
            end
            StRetIe: begin
                cp0_WE       = 1'b1;
                cp0_rW       = CP0_IE;
                cp0_W        = 32'h1;
                w_next_state = StRetJump;
            end
            StRetJump: begin
                redirect     = 1'b1;
                redirect_pc  = cp0_EPC;
                w_next_state = StIdle;
            end
            default: begin
                w_next_state = StInitIe;
            end
        endcase
        if (in_RST) begin
            cp0_WE      = 1'b0;
            cp0_rW      = 2'd0;
            cp0_W       = 32'd0;
            cp0_rA      = 3'd0;
            cpu_stall   = 1'b1;
            redirect    = 1'b0;
            redirect_pc = 32'd0;
            irq_ack     = '0;
        end
    end

    // State and sequencing registers with synchronous reset.
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            r_state  <= StInitIe;
            r_pend   <= '0;
            r_irq_q  <= '0;
            r_ret_pc <= 32'd0;
            r_sel    <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_pend  <= w_pend_next;
            r_irq_q <= irq_in;
            if (w_take) begin
                r_ret_pc <= pc_next;
            end
            if (w_sel_load) begin
                r_sel <= w_enc_idx;
            end
        end
    end

endmodule
